// File: rtl/product_cursor_ctrl_if.sv
// rtl/product_cursor_ctrl_if.sv - button, frame and basket-read signal bundle for product_cursor_ctrl
interface product_cursor_ctrl_if #(
    parameter int PRODUCT_COUNT = 12
);
    logic                     BTN_LEFT;
    logic                     BTN_RIGHT;
    logic                     BTN_UP;
    logic                     BTN_DOWN;
    logic                     BTN_ADD;
    logic                     BTN_REMOVE;
    logic                     SW2;
    logic                     FrameStart;
    logic [3:0]               BasketRdIdx;
    logic [PRODUCT_COUNT-1:0] HighlightedProductList;
    logic [3:0]               BasketRdID;
    logic [3:0]               BasketLen;
    logic                     Busy;
    logic                     AddReject;

    modport master (
        output BTN_LEFT, BTN_RIGHT, BTN_UP, BTN_DOWN, BTN_ADD, BTN_REMOVE,
        output SW2, FrameStart, BasketRdIdx,
        input  HighlightedProductList, BasketRdID, BasketLen, Busy, AddReject
    );

    modport slave (
        input  BTN_LEFT, BTN_RIGHT, BTN_UP, BTN_DOWN, BTN_ADD, BTN_REMOVE,
        input  SW2, FrameStart, BasketRdIdx,
        output HighlightedProductList, BasketRdID, BasketLen, Busy, AddReject
    );
endinterface

// File: rtl/product_cursor_ctrl.sv
// rtl/product_cursor_ctrl.sv - grid/basket cursor, ordered basket and frame-aligned highlight
module product_cursor_ctrl #(
    parameter int PRODUCT_COUNT = 12,
    parameter int GRID_COLS     = 4,
    parameter int BASKET_DEPTH  = 12
) (
    input  logic                CLK,
    input  logic                RST_N,
    product_cursor_ctrl_if.slave bus
);
    localparam logic [3:0] COLS      = 4'(GRID_COLS);
    localparam logic [3:0] LAST_BASE = 4'(PRODUCT_COUNT - GRID_COLS);
    localparam logic [3:0] DEPTH     = 4'(BASKET_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state_q, state_d;
    logic [5:0]               btn, btn_prev, ev;
    logic                     mode_q;
    logic [3:0]               gpos_q, gpos_d, bpos_q, bpos_d, len_q, len_d, ptr_q, ptr_d;
    logic [3:0]               entry_q [BASKET_DEPTH];
    logic                     wr_en;
    logic [3:0]               wr_idx, wr_data;
    logic                     reject_d, reject_q;
    logic [3:0]               col;
    logic [PRODUCT_COUNT-1:0] pending, hl_q;

    // Bit order doubles as the priority order: REMOVE highest, RIGHT lowest.
    assign btn = {bus.BTN_REMOVE, bus.BTN_ADD, bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT};
    assign ev  = btn & ~btn_prev;
    assign col = gpos_q % COLS;

    // Keep the basket cursor on a valid entry after the basket shrinks.
    function automatic logic [3:0] clamp(input logic [3:0] b, input logic [3:0] new_len);
        if (new_len == 4'd0)          return 4'd0;
        else if (b > new_len - 4'd1)  return new_len - 4'd1;
        else                          return b;
    endfunction

    // State register for the removal shifter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: one prioritised event per idle cycle, compaction while shifting.
    always_comb begin
        state_d  = state_q;
        gpos_d   = gpos_q;
        bpos_d   = bpos_q;
        len_d    = len_q;
        ptr_d    = ptr_q;
        wr_en    = 1'b0;
        wr_idx   = ptr_q;
        wr_data  = 4'd0;
        reject_d = 1'b0;
        case (state_q)
            SHIFT: begin
                wr_en   = 1'b1;
                wr_data = entry_q[ptr_q + 4'd1];
                ptr_d   = ptr_q + 4'd1;
                if (ptr_q + 4'd1 == len_q - 4'd1) begin
                    len_d   = len_q - 4'd1;
                    bpos_d  = clamp(bpos_q, len_q - 4'd1);
                    state_d = IDLE;
                end
            end
            default: begin
                if (ev[5]) begin
                    if (mode_q && len_q != 4'd0) begin
                        if (bpos_q == len_q - 4'd1) begin
                            len_d  = len_q - 4'd1;
                            bpos_d = clamp(bpos_q, len_q - 4'd1);
                        end else begin
                            ptr_d   = bpos_q;
                            state_d = SHIFT;
                        end
                    end
                end else if (ev[4]) begin
                    if (!mode_q) begin
                        if (len_q < DEPTH) begin
                            wr_en   = 1'b1;
                            wr_idx  = len_q;
                            wr_data = gpos_q;
                            len_d   = len_q + 4'd1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end else if (ev[3]) begin
                    if (!mode_q)               gpos_d = (gpos_q < COLS) ? gpos_q + LAST_BASE : gpos_q - COLS;
                    else if (bpos_q != 4'd0)   bpos_d = bpos_q - 4'd1;
                end else if (ev[2]) begin
                    if (!mode_q)               gpos_d = (gpos_q >= LAST_BASE) ? gpos_q - LAST_BASE : gpos_q + COLS;
                    else if (len_q != 4'd0 && bpos_q < len_q - 4'd1) bpos_d = bpos_q + 4'd1;
                end else if (ev[1]) begin
                    if (!mode_q)               gpos_d = (col == 4'd0) ? gpos_q + COLS - 4'd1 : gpos_q - 4'd1;
                end else if (ev[0]) begin
                    if (!mode_q)               gpos_d = (col == COLS - 4'd1) ? gpos_q - (COLS - 4'd1) : gpos_q + 4'd1;
                end
            end
        endcase
    end

    // Highlight source: grid cursor in grid view, basket cursor (if any entries) in basket view.
    always_comb begin
        pending = '0;
        if (!mode_q)               pending[gpos_q] = 1'b1;
        else if (len_q != 4'd0)    pending[bpos_q] = 1'b1;
    end

    // Datapath registers; edge flops run even while shifting so held buttons never retrigger.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_prev <= '0;
            mode_q   <= 1'b0;
            gpos_q   <= 4'd0;
            bpos_q   <= 4'd0;
            len_q    <= 4'd0;
            ptr_q    <= 4'd0;
            reject_q <= 1'b0;
            hl_q     <= '0;
            for (int i = 0; i < BASKET_DEPTH; i++) entry_q[i] <= 4'd0;
        end else begin
            btn_prev <= btn;
            mode_q   <= bus.SW2;
            gpos_q   <= gpos_d;
            bpos_q   <= bpos_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
            reject_q <= reject_d;
            if (wr_en)          entry_q[wr_idx] <= wr_data;
            if (bus.FrameStart) hl_q <= pending;
        end
    end

    assign bus.HighlightedProductList = hl_q;
    assign bus.BasketRdID             = (bus.BasketRdIdx < len_q) ? entry_q[bus.BasketRdIdx] : 4'd0;
    assign bus.BasketLen              = len_q;
    assign bus.Busy                   = (state_q == SHIFT);
    assign bus.AddReject              = reject_q;
endmodule

// File: tb/tb_product_cursor_ctrl.sv
// tb/tb_product_cursor_ctrl.sv - directed scoreboard bench for product_cursor_ctrl
module tb_product_cursor_ctrl;
    logic CLK = 1'b0;
    logic RST_N;

    product_cursor_ctrl_if bus ();

    product_cursor_ctrl dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    // bit order: 5 REMOVE, 4 ADD, 3 UP, 2 DOWN, 1 LEFT, 0 RIGHT
    localparam int B_RIGHT = 0, B_LEFT = 1, B_DOWN = 2, B_UP = 3, B_ADD = 4, B_REM = 5;
    logic [5:0] btn = '0;

    always_comb begin
        bus.BTN_RIGHT  = btn[B_RIGHT];
        bus.BTN_LEFT   = btn[B_LEFT];
        bus.BTN_DOWN   = btn[B_DOWN];
        bus.BTN_UP     = btn[B_UP];
        bus.BTN_ADD    = btn[B_ADD];
        bus.BTN_REMOVE = btn[B_REM];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check_val(input logic [15:0] obs);
        exp_t e;
        e = sb_q.pop_front();
        n_total++;
        assert (obs === e.val) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        tick();
        btn[b] = 1'b0;
        tick();
    endtask

    task automatic frame();
        bus.FrameStart = 1'b1;
        tick();
        bus.FrameStart = 1'b0;
    endtask

    task automatic do_reset();
        btn   = '0;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    int cnt;

    initial begin
        RST_N           = 1'b0;
        bus.SW2         = 1'b0;
        bus.FrameStart  = 1'b0;
        bus.BasketRdIdx = 4'd0;
        tick();

        // reset values
        expect_val("rst_hl", 16'h000);  check_val(16'(bus.HighlightedProductList));
        expect_val("rst_len", 16'd0);   check_val(16'(bus.BasketLen));
        expect_val("rst_busy", 16'd0);  check_val(16'(bus.Busy));
        expect_val("rst_rej", 16'd0);   check_val(16'(bus.AddReject));
        expect_val("rst_rdid", 16'd0);  check_val(16'(bus.BasketRdID));
        RST_N = 1'b1;
        tick();

        // grid wrap: gpos 0 -LEFT-> 3 -UP-> 11
        press(B_LEFT);
        frame();
        expect_val("wrap_left", 16'h008); check_val(16'(bus.HighlightedProductList));
        press(B_UP);
        frame();
        expect_val("wrap_up", 16'h800);   check_val(16'(bus.HighlightedProductList));

        // cursor move without FrameStart: highlight holds; 11 -RIGHT-> 8
        press(B_RIGHT);
        expect_val("hold_no_frame", 16'h800); check_val(16'(bus.HighlightedProductList));
        frame();
        expect_val("wrap_right", 16'h100);    check_val(16'(bus.HighlightedProductList));

        // down from bottom row wraps: 8 -DOWN-> 0
        press(B_DOWN);
        frame();
        expect_val("wrap_down", 16'h001);     check_val(16'(bus.HighlightedProductList));

        // reach gpos 5: 0 -DOWN-> 4 -RIGHT-> 5
        press(B_DOWN);
        press(B_RIGHT);
        frame();
        expect_val("gpos5", 16'h020);         check_val(16'(bus.HighlightedProductList));

        // fill basket and reject the 13th add
        for (int i = 0; i < 12; i++) press(B_ADD);
        expect_val("full_len", 16'd12);       check_val(16'(bus.BasketLen));
        for (int i = 0; i < 13; i++) begin
            bus.BasketRdIdx = 4'(i);
            #1;
            expect_val($sformatf("full_id%0d", i), (i < 12) ? 16'd5 : 16'd0);
            check_val(16'(bus.BasketRdID));
        end
        btn[B_ADD] = 1'b1;
        tick();
        expect_val("reject_pulse", 16'd1);    check_val(16'(bus.AddReject));
        expect_val("reject_len", 16'd12);     check_val(16'(bus.BasketLen));
        btn[B_ADD] = 1'b0;
        tick();
        expect_val("reject_end", 16'd0);      check_val(16'(bus.AddReject));

        // middle removal from basket 0,1,2,3
        do_reset();
        press(B_ADD); press(B_RIGHT);
        press(B_ADD); press(B_RIGHT);
        press(B_ADD); press(B_RIGHT);
        press(B_ADD);
        bus.SW2 = 1'b1;
        tick();
        press(B_DOWN);
        btn[B_REM] = 1'b1;
        tick();
        cnt = 0;
        while (bus.Busy === 1'b1 && cnt < 10) begin
            cnt++;
            if (cnt == 1) btn[B_DOWN] = 1'b1;
            tick();
        end
        expect_val("mid_busy_cycles", 16'd2); check_val(16'(cnt));
        tick();
        tick();
        btn = '0;
        tick();
        expect_val("mid_len", 16'd3);         check_val(16'(bus.BasketLen));
        for (int i = 0; i < 3; i++) begin
            bus.BasketRdIdx = 4'(i);
            #1;
            expect_val($sformatf("mid_id%0d", i), (i == 0) ? 16'd0 : 16'(i + 1));
            check_val(16'(bus.BasketRdID));
        end
        frame();
        expect_val("mid_hl", 16'h002);        check_val(16'(bus.HighlightedProductList));

        // tail removal: bpos 1 -DOWN-> 2, remove takes no shift cycles
        press(B_DOWN);
        btn[B_REM] = 1'b1;
        tick();
        expect_val("tail_busy", 16'd0);       check_val(16'(bus.Busy));
        expect_val("tail_len", 16'd2);        check_val(16'(bus.BasketLen));
        btn[B_REM] = 1'b0;
        tick();
        frame();
        expect_val("tail_hl", 16'h002);       check_val(16'(bus.HighlightedProductList));

        // ADD + RIGHT together in grid view: add wins, gpos stays 3
        bus.SW2 = 1'b0;
        tick();
        btn[B_ADD]   = 1'b1;
        btn[B_RIGHT] = 1'b1;
        tick();
        btn = '0;
        tick();
        expect_val("simul_len", 16'd3);       check_val(16'(bus.BasketLen));
        bus.BasketRdIdx = 4'd2;
        #1;
        expect_val("simul_id", 16'd3);        check_val(16'(bus.BasketRdID));
        frame();
        expect_val("simul_hl", 16'h008);      check_val(16'(bus.HighlightedProductList));

        // asynchronous reset during a shift
        bus.SW2 = 1'b1;
        tick();
        btn[B_REM] = 1'b1;
        tick();
        expect_val("pre_rst_busy", 16'd1);    check_val(16'(bus.Busy));
        #2;
        RST_N = 1'b0;
        #1;
        expect_val("arst_hl", 16'h000);       check_val(16'(bus.HighlightedProductList));
        expect_val("arst_len", 16'd0);        check_val(16'(bus.BasketLen));
        expect_val("arst_busy", 16'd0);       check_val(16'(bus.Busy));
        expect_val("arst_rej", 16'd0);        check_val(16'(bus.AddReject));
        btn = '0;
        tick();
        RST_N = 1'b1;
        tick();

        // basket view with an empty basket shows no highlight
        bus.SW2 = 1'b0;
        tick();
        frame();
        expect_val("grid_hl0", 16'h001);      check_val(16'(bus.HighlightedProductList));
        bus.SW2 = 1'b1;
        tick();
        frame();
        expect_val("empty_basket_hl", 16'h000); check_val(16'(bus.HighlightedProductList));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/product_cursor_ctrl.md
# product_cursor_ctrl

Selection and basket controller for the sale terminal display. It turns debounced push-button levels into a grid cursor over the 12 product images and keeps an ordered basket of up to 12 product IDs. It drives the one-hot `HighlightedProductList` consumed by the image/basket locator, updating it only on frame boundaries so the highlight never tears mid-frame. It also exposes a basket read port for the basket-list renderer.

## Interface
- `PRODUCT_COUNT`, 12: number of products, grid cells and highlight bits.
- `GRID_COLS`, 4: grid columns; rows = PRODUCT_COUNT/GRID_COLS = 3.
- `BASKET_DEPTH`, 12: maximum basket entries.
- `CLK`  in  1  single clock.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `BTN_LEFT`, `BTN_RIGHT`, `BTN_UP`, `BTN_DOWN`, `BTN_ADD`, `BTN_REMOVE`  in  1 each  debounced, CLK-synchronous button levels.
- `SW2`  in  1  view mode: 0 = product grid, 1 = basket list.
- `FrameStart`  in  1  one-cycle pulse at the start of vertical blanking.
- `BasketRdIdx`  in  4  basket read index.
- `HighlightedProductList`  out  12  registered one-hot highlight, frame-aligned.
- `BasketRdID`  out  4  product ID at `BasketRdIdx`; combinational; 0 when idx ≥ `BasketLen`.
- `BasketLen`  out  4  number of valid basket entries, 0..12.
- `Busy`  out  1  high while a removal shift is in progress.
- `AddReject`  out  1  one-cycle pulse when an add is attempted on a full basket.

## Operation
- **Edge detect:** one flop per button (reset 0). event = level & ~prev.
- **Priority:** only one event is processed per cycle, in the order REMOVE > ADD > UP > DOWN > LEFT > RIGHT. Lower-priority events in the same cycle are dropped.
- **Mode:** `SW2` is registered once (reset 0). All mode decisions use the registered value.
- **Grid cursor:** `gpos` 0..11, reset 0. row = gpos/4, col = gpos%4.
  - LEFT/RIGHT wrap within the row: col 0 LEFT → col 3.
  - UP/DOWN wrap within the column: row 0 UP → row 2.
  - Arrows move the grid cursor only when mode = 0.
- **Basket cursor:** `bpos`, reset 0. Active only when mode = 1.
  - UP: `bpos` − 1, saturating at 0.
  - DOWN: `bpos` + 1, saturating at `BasketLen` − 1. No move when `BasketLen` = 0.
  - LEFT/RIGHT are ignored.
- **ADD** (mode 0 only):
  - If `BasketLen` < 12: entry[`BasketLen`] ← `gpos`, `BasketLen` + 1.
  - Else: `AddReject` pulses for one cycle and nothing else changes.
  - Duplicates are allowed. ADD is ignored in mode 1.
- **REMOVE** (mode 1 only, `BasketLen` > 0): removes entry[`bpos`]. Ignored in mode 0 or when the basket is empty.
- **FSM states:** IDLE, SHIFT.
  - IDLE + REMOVE with k = `bpos` = `BasketLen` − 1: `BasketLen` − 1, stay in IDLE.
  - IDLE + REMOVE otherwise: ptr ← k, go to SHIFT.
  - SHIFT, each cycle: entry[ptr] ← entry[ptr+1], ptr + 1. When ptr + 1 = `BasketLen` − 1: `BasketLen` − 1, return to IDLE.
  - `Busy` = (state == SHIFT).
  - All button events are dropped while `Busy`. Edge flops keep updating, so a button held through SHIFT does not retrigger.
- **Cursor clamp:** whenever `BasketLen` decrements, `bpos` ← min(`bpos`, new `BasketLen` − 1), floored at 0.
- **Highlight:** pending = mode 0 ? onehot(`gpos`) : (`BasketLen` > 0 ? onehot(`bpos`) : 0). `HighlightedProductList` ← pending on each `FrameStart`; otherwise it holds.
- **Width rules:** all indices are 4-bit unsigned; `BasketLen` never exceeds 12.

## Timing
- **Reset values:** `HighlightedProductList` = 0, `BasketLen` = 0, `Busy` = 0, `AddReject` = 0. `gpos`, `bpos`, entries, ptr = 0. FSM in IDLE.
- **Cursor/length latency:** an event sampled at edge e is visible in `gpos`/`bpos`/`BasketLen` after edge e.
- **`AddReject`:** high for exactly the cycle after edge e.
- **Highlight latency:** `HighlightedProductList` reflects state as of the `FrameStart` edge. A cursor change on the same edge as `FrameStart` appears at the next `FrameStart`.
- **Removal latency:** `BasketLen` − 1 − k SHIFT cycles. The `BasketLen` decrement and `Busy` fall happen on the same edge.
- **`BasketRdID` during SHIFT:** may show partially shifted entries; the renderer samples only when `Busy` = 0.
- **Mode change mid-SHIFT:** the shift completes unaffected; only the highlight source changes.
- **`RST_N` low mid-SHIFT:** immediate clear, basket empty.

## Test plan
- **Grid wrap:** reset; mode 0; LEFT; FrameStart → `HighlightedProductList` = 12'h008. Then UP, FrameStart → 12'h800.
- **Add and reject:** mode 0, `gpos` = 5; ADD ×12 → `BasketLen` = 12, every `BasketRdID` = 5. 13th ADD → `AddReject` pulses one cycle, `BasketLen` stays 12.
- **Middle removal:** basket IDs 0,1,2,3; mode 1; DOWN; REMOVE.
  - `Busy` high for exactly 2 cycles.
  - Then `BasketLen` = 3 and entries read 0,2,3.
  - `bpos` = 1; next FrameStart → highlight 12'h002.
- **Tail removal and clamp:** basket of 3, `bpos` = 2; REMOVE → `Busy` never asserts, `BasketLen` = 2 after one edge, `bpos` = 1.
- **Simultaneous events and busy drop:**
  - ADD + RIGHT on the same edge in mode 0 → entry added, `gpos` unchanged.
  - A button edge during SHIFT is ignored.
  - Holding REMOVE through SHIFT does not trigger a second removal.
- **Frame alignment and reset:**
  - Cursor moves without FrameStart → highlight stays unchanged.
  - Assert `RST_N` low mid-SHIFT → all outputs 0 asynchronously.
  - Mode 1 with an empty basket → highlight 0 after FrameStart.
